axi_burst_beat_gen: RTL and testbench
=====================================

Name: axi_burst_beat_gen

Overview:
- Parametrised AXI4 burst sequencer for the AXI slave datapath of the crypto IPs (AES and successors).
- Accepts burst commands (AxID/AxADDR/AxLEN/AxSIZE/AxBURST), queues them, and emits one address/index/last record per data beat.
- Supports FIXED, INCR and WRAP bursts with illegal-command flagging.
- One instance serves the AW path and one the AR path of the slave wrapper.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, bus data width in bits; legal sizes are 0..log2(DATA_WIDTH/8)
ID_WIDTH, 4, AXI ID width
CMD_DEPTH, 4, command queue depth; power of 2, >= 2

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  synchronous, active-high reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command ready (queue not full)
cmd_id  in  ID_WIDTH  burst ID
cmd_addr  in  ADDR_WIDTH  start address
cmd_len  in  8  beats minus 1
cmd_size  in  3  log2 bytes per beat
cmd_burst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
beat_valid  out  1  beat record valid
beat_ready  in  1  beat consumed
beat_id  out  ID_WIDTH  ID of current burst
beat_addr  out  ADDR_WIDTH  byte address of current beat
beat_idx  out  8  beat index, 0..len
beat_last  out  1  final beat of burst
beat_err  out  1  burst illegal; consumer answers SLVERR

Behaviour:
- Reset, while ARESET is high at an edge:
  - Queue emptied; FSM to IDLE.
  - beat_valid, beat_last, beat_err = 0; beat_addr, beat_idx, beat_id = 0.
  - cmd_ready reads 0 while ARESET is high.
  - Reset mid-burst drops the remaining beats and all queued commands.
- Command queue:
  - Push on cmd_valid & cmd_ready.
  - cmd_ready = !full, computed combinationally from the count; no push-through when full.
  - Push and pop in the same cycle are both allowed; count unchanged.
- FSM IDLE:
  - Queue non-empty: pop, load the beat registers, go to BURST.
  - beat_valid rises at the next edge.
  - Minimum latency: command accepted at edge N -> first beat_valid after edge N+2.
- FSM BURST:
  - beat_* outputs stay stable until beat_valid & beat_ready.
  - On a non-last handshake: beat_idx+1, beat_addr advances.
  - On a last handshake with the queue non-empty: pop and load the next command in the same edge, so there is no bubble.
  - On a last handshake with the queue empty: go to IDLE, beat_valid=0.
- Address rules (bytes = 1<<size):
  - FIXED: every beat uses cmd_addr.
  - INCR: beat 0 = cmd_addr, which may be unaligned. Beat k = (cmd_addr & ~(bytes-1)) + k*bytes, modulo 2^ADDR_WIDTH.
  - WRAP: wb = (len+1)*bytes; lower = addr & ~(wb-1). next = lower + ((cur + bytes - lower) mod wb).
- beat_last = (beat_idx == len); a len=0 burst gives a single beat with last=1.
- Error (beat_err=1 on all beats of the burst; beats are still generated normally so the consumer drains W / returns R):
  - size > log2(DATA_WIDTH/8)
  - burst == 11
  - WRAP with len not in {1,3,7,15}
  - WRAP with cmd_addr not aligned to bytes
  - Erroneous bursts use INCR addressing.

Optional Feature:
- Macro AXI_BURST_4K_CHECK_EN.
- Defined: an INCR burst whose last byte lies in a different 4 KB page than cmd_addr sets beat_err on all its beats.
- Undefined: no page check; addresses cross the page boundary normally.

Decomposition:
- Package axi_burst_pkg:
  - burst_t enum (FIXED, INCR, WRAP, RSVD)
  - burst_cmd_t struct (id, addr, len, size, burst, err)
  - function next_beat_addr()
  - function cmd_is_illegal()
  - constant PAGE_BYTES = 4096
- Error is computed at push and stored in the queue.
- Sub-module axi_burst_cmd_fifo: synchronous FIFO of burst_cmd_t, CMD_DEPTH entries, full/empty/count outputs.

Test Plan:
1. INCR addr 0x0, len 7, size 2, beat_ready=1 -> addrs 0x00,0x04..0x1C; idx 0..7; last only on idx 7; err=0; first valid 2 cycles after accept.
2. Unaligned INCR addr 0x2, len 2, size 2 -> 0x02,0x04,0x08. FIXED addr 0x100, len 3 -> 0x100 four times.
3. WRAP addr 0x38, len 3, size 2 -> 0x38,0x3C,0x30,0x34; last on 0x34. WRAP len 2 -> 3 beats, err=1.
4. CMD_DEPTH=4, beat_ready=0, 6 commands offered -> 5 accepted (1 loaded, 4 queued), cmd_ready=0. Release ready -> all bursts back-to-back, no idle cycle between last and next beat 0.
5. size=3 with DATA_WIDTH=32, len 1 -> 2 beats, err=1. With AXI_BURST_4K_CHECK_EN: INCR addr 0xFF8, len 3, size 2 -> err=1; without it: addrs 0xFF8..0x1004, err=0.
6. ARESET high for 1 cycle after beat idx 3 of an 8-beat burst, with 2 commands queued -> beat_valid=0 next cycle, no further beats, cmd_ready=1 after reset release.

Source files
------------

// File: rtl/axi_burst_beat_gen_pkg.sv
// Shared types and address/legality helpers for the AXI burst beat generator.
// Optional feature macro: AXI_BURST_4K_CHECK_EN (INCR bursts crossing a 4 KB page are flagged).
package axi_burst_pkg;

  localparam int PAGE_BYTES = 4096;
  localparam int PAGE_SHIFT = $clog2(PAGE_BYTES);
  localparam int CMD_ADDR_W = 32;
  localparam int CMD_ID_W   = 4;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } beat_state_t;

  typedef struct packed {
    logic [CMD_ID_W-1:0]   id;
    logic [CMD_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    burst_t                burst;
    logic                  err;
  } burst_cmd_t;

  function automatic logic [63:0] size_mask(input logic [2:0] size);
    return (64'd1 << size) - 64'd1;
  endfunction

  function automatic logic cmd_is_illegal(
    input logic [63:0] addr,
    input logic [7:0]  len,
    input logic [2:0]  size,
    input burst_t      burst,
    input logic [2:0]  max_size
  );
    logic size_bad;
    logic rsvd_bad;
    logic wrap_len_bad;
    logic wrap_align_bad;
    logic page_bad;
`ifdef AXI_BURST_4K_CHECK_EN
    logic [63:0] last_byte;
`endif
    size_bad       = (size > max_size);
    rsvd_bad       = (burst == BURST_RSVD);
    wrap_len_bad   = (burst == BURST_WRAP) &&
                     !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
    wrap_align_bad = (burst == BURST_WRAP) && ((addr & size_mask(size)) != 64'd0);
`ifdef AXI_BURST_4K_CHECK_EN
    last_byte = (addr & ~size_mask(size)) + (({56'd0, len} + 64'd1) << size) - 64'd1;
    page_bad  = (burst == BURST_INCR) && ((last_byte >> PAGE_SHIFT) != (addr >> PAGE_SHIFT));
`else
    page_bad  = 1'b0;
`endif
    return size_bad | rsvd_bad | wrap_len_bad | wrap_align_bad | page_bad;
  endfunction

  // Illegal bursts fall back to INCR stepping so the consumer still sees sane addresses.
  function automatic logic [63:0] next_beat_addr(
    input logic [63:0] start,
    input logic [63:0] cur,
    input logic [7:0]  len,
    input logic [2:0]  size,
    input burst_t      burst,
    input logic        err
  );
    logic [63:0] bytes;
    logic [63:0] wb;
    logic [63:0] lower;
    logic [63:0] nxt;
    bytes = 64'd1 << size;
    wb    = ({56'd0, len} + 64'd1) << size;
    lower = start & ~(wb - 64'd1);
    if (err || (burst == BURST_INCR)) begin
      nxt = (cur & ~(bytes - 64'd1)) + bytes;
    end else if (burst == BURST_FIXED) begin
      nxt = cur;
    end else begin
      nxt = lower + ((cur + bytes - lower) & (wb - 64'd1));
    end
    return nxt;
  endfunction

endpackage

// File: rtl/axi_burst_beat_gen_if.sv
// Command and beat handshake bundle of the AXI burst beat generator.
// master = command producer / beat consumer, slave = the generator.
interface axi_burst_beat_gen_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ID_WIDTH-1:0]   cmd_id;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [7:0]            cmd_len;
  logic [2:0]            cmd_size;
  logic [1:0]            cmd_burst;

  logic                  beat_valid;
  logic                  beat_ready;
  logic [ID_WIDTH-1:0]   beat_id;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [7:0]            beat_idx;
  logic                  beat_last;
  logic                  beat_err;

  modport master (
    output cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
    input  cmd_ready, beat_valid, beat_id, beat_addr, beat_idx, beat_last, beat_err
  );

  modport slave (
    input  cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
    output cmd_ready, beat_valid, beat_id, beat_addr, beat_idx, beat_last, beat_err
  );
endinterface

// File: rtl/axi_burst_beat_gen_cmd_fifo.sv
// Synchronous command queue with combinational head read; push is refused when full.
module axi_burst_cmd_fifo
  import axi_burst_pkg::*;
#(
  parameter type T     = burst_cmd_t,
  parameter int  DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  T              i_din,
  input  logic          i_pop,
  output T              o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/axi_burst_beat_gen.sv
// AXI4 burst sequencer: queues burst commands and emits one address/index/last record per beat.
// Optional feature macro: AXI_BURST_4K_CHECK_EN (handled inside axi_burst_pkg::cmd_is_illegal).
module axi_burst_beat_gen
  import axi_burst_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int CMD_DEPTH  = 4
) (
  input logic                 ACLK,
  input logic                 ARESET,
  axi_burst_beat_gen_if.slave bus
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));
  localparam int         CW       = $clog2(CMD_DEPTH) + 1;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    burst_t                burst;
    logic                  err;
  } cmd_t;

  cmd_t                  w_push_cmd;
  cmd_t                  w_head;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [CW-1:0]         w_count;
  logic                  w_hs;

  beat_state_t           r_state;
  logic                  r_q_seen;
  logic                  r_valid;
  logic                  r_last;
  logic                  r_err;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_start;
  logic [7:0]            r_idx;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  burst_t                r_burst;

  assign bus.cmd_ready = !w_full && !ARESET;
  assign w_push        = bus.cmd_valid && bus.cmd_ready;
  assign w_hs          = r_valid && bus.beat_ready;

  // Legality is resolved once at push and travels with the command.
  always_comb begin
    w_push_cmd.id    = bus.cmd_id;
    w_push_cmd.addr  = bus.cmd_addr;
    w_push_cmd.len   = bus.cmd_len;
    w_push_cmd.size  = bus.cmd_size;
    w_push_cmd.burst = burst_t'(bus.cmd_burst);
    w_push_cmd.err   = cmd_is_illegal(64'(bus.cmd_addr), bus.cmd_len, bus.cmd_size,
                                      burst_t'(bus.cmd_burst), MAX_SIZE);
  end

  axi_burst_cmd_fifo #(
    .T     (cmd_t),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .i_clk   (ACLK),
    .i_rst   (ARESET),
    .i_push  (w_push),
    .i_din   (w_push_cmd),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // IDLE sees occupancy one edge late, giving a two-edge accept-to-beat latency.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      ST_IDLE:  w_pop = r_q_seen && !w_empty;
      ST_BURST: w_pop = w_hs && r_last && !w_empty;
      default:  w_pop = 1'b0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state  <= ST_IDLE;
      r_q_seen <= 1'b0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_err    <= 1'b0;
      r_id     <= '0;
      r_addr   <= '0;
      r_start  <= '0;
      r_idx    <= 8'd0;
      r_len    <= 8'd0;
      r_size   <= 3'd0;
      r_burst  <= BURST_FIXED;
    end else begin
      r_q_seen <= (w_count != '0);
      if (w_pop) begin
        r_state <= ST_BURST;
        r_valid <= 1'b1;
        r_id    <= w_head.id;
        r_addr  <= w_head.addr;
        r_start <= w_head.addr;
        r_idx   <= 8'd0;
        r_len   <= w_head.len;
        r_last  <= (w_head.len == 8'd0);
        r_size  <= w_head.size;
        r_burst <= w_head.burst;
        r_err   <= w_head.err;
      end else begin
        case (r_state)
          ST_BURST: begin
            if (w_hs && !r_last) begin
              r_idx  <= r_idx + 8'd1;
              r_last <= ((r_idx + 8'd1) == r_len);
              r_addr <= ADDR_WIDTH'(next_beat_addr(64'(r_start), 64'(r_addr), r_len,
                                                   r_size, r_burst, r_err));
            end else if (w_hs) begin
              r_valid <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_valid <= r_valid;
            end
          end
          ST_IDLE:  r_valid <= 1'b0;
          default:  r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.beat_valid = r_valid;
  assign bus.beat_id    = r_id;
  assign bus.beat_addr  = r_addr;
  assign bus.beat_idx   = r_idx;
  assign bus.beat_last  = r_last;
  assign bus.beat_err   = r_err;

endmodule

// File: tb/tb_axi_burst_beat_gen.sv
// Directed, table-driven bench for axi_burst_beat_gen plus queue-full and reset sequences.
module tb_axi_burst_beat_gen;

  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  axi_burst_beat_gen_if #(.ADDR_WIDTH(32), .ID_WIDTH(4)) bus ();

  axi_burst_beat_gen #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .ID_WIDTH   (4),
    .CMD_DEPTH  (4)
  ) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );

  typedef struct {
    logic [3:0]            id;
    logic [31:0]           addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [0:7][31:0]      exp_addr;
    logic                  exp_err;
  } vec_t;

  vec_t vecs [10];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_cmd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    logic accepted;
    accepted      = 1'b0;
    bus.cmd_id    = id;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    bus.cmd_size  = size;
    bus.cmd_burst = burst;
    bus.cmd_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (!accepted) begin
        if (bus.cmd_ready) accepted = 1'b1;
        tick();
      end
    end
    bus.cmd_valid = 1'b0;
    check("cmd_accept", 64'(accepted), 64'd1);
  endtask

  // Sends no cycles here: advances only until beat_valid or the budget runs out.
  task automatic wait_valid(input string name);
    int t;
    t = 0;
    while (!bus.beat_valid && t < 20) begin
      tick();
      t++;
    end
    check(name, 64'(bus.beat_valid), 64'd1);
  endtask

  initial begin
    int  sent;
    logic rdy;
    logic seen;

    bus.cmd_valid  = 1'b0;
    bus.cmd_id     = 4'd0;
    bus.cmd_addr   = 32'd0;
    bus.cmd_len    = 8'd0;
    bus.cmd_size   = 3'd0;
    bus.cmd_burst  = 2'b00;
    bus.beat_ready = 1'b0;
    ARESET         = 1'b1;

    vecs[0] = '{4'h1, 32'h0,   8'd7, 3'd2, 2'b01,
                {32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C}, 1'b0};
    vecs[1] = '{4'h2, 32'h2,   8'd2, 3'd2, 2'b01,
                {32'h02, 32'h04, 32'h08, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, 1'b0};
    vecs[2] = '{4'h3, 32'h100, 8'd3, 3'd2, 2'b00,
                {32'h100, 32'h100, 32'h100, 32'h100, 32'h0, 32'h0, 32'h0, 32'h0}, 1'b0};
    vecs[3] = '{4'h4, 32'h38,  8'd3, 3'd2, 2'b10,
                {32'h38, 32'h3C, 32'h30, 32'h34, 32'h0, 32'h0, 32'h0, 32'h0}, 1'b0};
    vecs[4] = '{4'h5, 32'h40,  8'd2, 3'd2, 2'b10,
                {32'h40, 32'h44, 32'h48, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, 1'b1};
    vecs[5] = '{4'h6, 32'h10,  8'd1, 3'd3, 2'b01,
                {32'h10, 32'h18, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, 1'b1};
    vecs[6] = '{4'h7, 32'h20,  8'd1, 3'd0, 2'b11,
                {32'h20, 32'h21, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, 1'b1};
    vecs[7] = '{4'h8, 32'h36,  8'd1, 3'd2, 2'b10,
                {32'h36, 32'h38, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, 1'b1};
    vecs[8] = '{4'h9, 32'h0C,  8'd7, 3'd1, 2'b10,
                {32'h0C, 32'h0E, 32'h00, 32'h02, 32'h04, 32'h06, 32'h08, 32'h0A}, 1'b0};
    vecs[9] = '{4'hA, 32'hFF8, 8'd3, 3'd2, 2'b01,
                {32'hFF8, 32'hFFC, 32'h1000, 32'h1004, 32'h0, 32'h0, 32'h0, 32'h0}, 1'b0};
`ifdef AXI_BURST_4K_CHECK_EN
    vecs[9].exp_err = 1'b1;
`else
    vecs[9].exp_err = 1'b0;
`endif

    // Reset state
    tick();
    tick();
    tick();
    check("rst_outputs", {bus.beat_valid, bus.beat_last, bus.beat_err, bus.beat_id,
                          bus.beat_addr, bus.beat_idx}, 64'd0);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    ARESET = 1'b0;
    tick();
    check("cmd_ready_after_rst", 64'(bus.cmd_ready), 64'd1);

    // Table-driven bursts
    for (int i = 0; i < 10; i++) begin
      send_cmd(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst);
      if (i == 0) begin
        check("lat_edge_n", 64'(bus.beat_valid), 64'd0);
        tick();
        check("lat_edge_n1", 64'(bus.beat_valid), 64'd0);
        tick();
        check("lat_edge_n2", 64'(bus.beat_valid), 64'd1);
      end else begin
        wait_valid("vec_first_valid");
      end
      bus.beat_ready = 1'b1;
      for (int k = 0; k <= int'(vecs[i].len); k++) begin
        check($sformatf("vec%0d_beat%0d", i, k),
              {bus.beat_valid, bus.beat_id, bus.beat_addr, bus.beat_idx, bus.beat_last, bus.beat_err},
              {1'b1, vecs[i].id, vecs[i].exp_addr[k], 8'(k), (k == int'(vecs[i].len)), vecs[i].exp_err});
        tick();
      end
      bus.beat_ready = 1'b0;
      check($sformatf("vec%0d_idle", i), 64'(bus.beat_valid), 64'd0);
    end

    // Queue full with consumer stalled, then back-to-back drain
    sent = 0;
    for (int c = 0; c < 12; c++) begin
      bus.cmd_id    = 4'(sent);
      bus.cmd_addr  = 32'(sent * 256);
      bus.cmd_len   = 8'd1;
      bus.cmd_size  = 3'd2;
      bus.cmd_burst = 2'b01;
      bus.cmd_valid = (sent < 6);
      rdy = bus.cmd_ready && bus.cmd_valid;
      tick();
      if (rdy) sent++;
    end
    bus.cmd_valid = 1'b0;
    check("q_accepted", 64'(sent), 64'd5);
    check("q_full_ready", 64'(bus.cmd_ready), 64'd0);
    check("q_stall_hold", {bus.beat_valid, bus.beat_addr, bus.beat_idx}, {1'b1, 32'h0, 8'd0});
    bus.beat_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("b2b_cmd%0d_beat%0d", j, k),
              {bus.beat_valid, bus.beat_id, bus.beat_addr, bus.beat_idx, bus.beat_last, bus.beat_err},
              {1'b1, 4'(j), 32'(j * 256 + k * 4), 8'(k), (k == 1), 1'b0});
        tick();
      end
    end
    bus.beat_ready = 1'b0;
    check("b2b_idle", 64'(bus.beat_valid), 64'd0);

    // Reset in the middle of a burst with commands queued
    send_cmd(4'hB, 32'h200, 8'd7, 3'd2, 2'b01);
    send_cmd(4'hC, 32'h300, 8'd1, 3'd2, 2'b01);
    send_cmd(4'hD, 32'h400, 8'd1, 3'd2, 2'b01);
    wait_valid("rst_mid_first_valid");
    bus.beat_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_mid_beat%0d", k), {bus.beat_idx, bus.beat_addr},
            {8'(k), 32'(32'h200 + k * 4)});
      tick();
    end
    ARESET = 1'b1;
    #1;
    check("rst_mid_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    tick();
    ARESET = 1'b0;
    check("rst_mid_cleared", {bus.beat_valid, bus.beat_idx, bus.beat_addr, bus.beat_last},
          64'd0);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.beat_valid) seen = 1'b1;
      tick();
    end
    check("rst_mid_no_beats", 64'(seen), 64'd0);
    check("rst_mid_cmd_ready_after", 64'(bus.cmd_ready), 64'd1);
    bus.beat_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
